// File: rtl/axi_xbar_pkg.sv
// Shared AXI channel structs and ID prefix helpers for the crossbar mux/demux pair.
// Module parameters of axi_mux_core must agree with the widths fixed here.
package axi_xbar_pkg;
  localparam int SLV_ID_W     = 4;
  localparam int NO_SLV_PORTS = 4;
  localparam int SEL_W        = $clog2(NO_SLV_PORTS);
  localparam int MST_ID_W     = SLV_ID_W + SEL_W;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STRB_W       = DATA_W / 8;

  typedef logic [SEL_W-1:0] idx_t;

  typedef struct packed {
    logic [SLV_ID_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } slv_ax_t;

  typedef struct packed {
    logic [MST_ID_W-1:0] id;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } mst_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_chan_t;

  typedef struct packed { logic [SLV_ID_W-1:0] id; logic [1:0] resp; } slv_b_t;
  typedef struct packed { logic [MST_ID_W-1:0] id; logic [1:0] resp; } mst_b_t;

  typedef struct packed {
    logic [SLV_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
    logic [1:0]          resp;
    logic                last;
  } slv_r_t;

  typedef struct packed {
    logic [MST_ID_W-1:0] id;
    logic [DATA_W-1:0]   data;
    logic [1:0]          resp;
    logic                last;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw; logic aw_valid;
    w_chan_t w;  logic w_valid;
    logic    b_ready;
    slv_ax_t ar; logic ar_valid;
    logic    r_ready;
  } slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    slv_b_t b; logic b_valid;
    slv_r_t r; logic r_valid;
  } slv_resp_t;

  typedef struct packed {
    mst_ax_t aw; logic aw_valid;
    w_chan_t w;  logic w_valid;
    logic    b_ready;
    mst_ax_t ar; logic ar_valid;
    logic    r_ready;
  } mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    mst_b_t b; logic b_valid;
    mst_r_t r; logic r_valid;
  } mst_resp_t;

  function automatic logic [MST_ID_W-1:0] prefix_id(idx_t idx, logic [SLV_ID_W-1:0] id);
    return {idx, id};
  endfunction

  function automatic logic [SLV_ID_W-1:0] strip_id(logic [MST_ID_W-1:0] id);
    return id[SLV_ID_W-1:0];
  endfunction
endpackage

// File: rtl/axi_mux_rr_arb.sv
// Round-robin arbiter with a grant freeze while the winning request is stalled.
// The pointer moves to winner+1 only on handshake.
module axi_mux_rr_arb #(
  parameter int N = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_lock,
  input  logic                 i_hs,
  output logic [$clog2(N)-1:0] o_gnt_idx,
  output logic                 o_gnt_valid
);
  localparam int SelW = $clog2(N);

  logic [SelW-1:0] r_ptr, r_lock_idx, w_rr_idx, w_cand;
  logic            w_found;

  always_comb begin
    w_rr_idx = r_ptr;
    w_cand   = r_ptr;
    w_found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_cand = SelW'((int'(r_ptr) + i) % N);
      if (!w_found && i_req[w_cand]) begin
        w_rr_idx = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // While locked, replay last cycle's grant so a newly valid port cannot steal it.
  assign o_gnt_idx   = i_lock ? r_lock_idx : w_rr_idx;
  assign o_gnt_valid = i_req[o_gnt_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= '0;
      r_lock_idx <= '0;
    end else begin
      r_lock_idx <= o_gnt_idx;
      if (i_hs) r_ptr <= (o_gnt_idx == SelW'(N-1)) ? '0 : o_gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/axi_mux_core.sv
// N:1 AXI4 mux: RR-arbitrates AW/AR, tags IDs with the source port, orders W by
// AW grant order through a small FIFO and routes B/R back by the ID prefix.
module axi_mux_core
  import axi_xbar_pkg::*;
#(
  parameter int  SlvIdWidth = SLV_ID_W,
  parameter int  NoSlvPorts = NO_SLV_PORTS,
  parameter int  MaxWTrans  = 8,
  parameter type slv_req_t  = axi_xbar_pkg::slv_req_t,
  parameter type slv_resp_t = axi_xbar_pkg::slv_resp_t,
  parameter type mst_req_t  = axi_xbar_pkg::mst_req_t,
  parameter type mst_resp_t = axi_xbar_pkg::mst_resp_t,
  localparam int SelectWidth = $clog2(NoSlvPorts)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  slv_req_t  [NoSlvPorts-1:0] slv_reqs_i,
  output slv_resp_t [NoSlvPorts-1:0] slv_resps_o,
  output mst_req_t                   mst_req_o,
  input  mst_resp_t                  mst_resp_i
);
  localparam int PtrW = $clog2(MaxWTrans);
  localparam int CntW = PtrW + 1;

  logic [NoSlvPorts-1:0]  w_aw_req, w_ar_req;
  logic [SelectWidth-1:0] w_aw_idx, w_ar_idx, w_w_idx, w_b_idx, w_r_idx;
  logic w_aw_gnt, w_ar_gnt, w_aw_hs, w_ar_hs, w_full, w_empty, w_pop;
  logic r_aw_lock, r_ar_lock;

  logic [SelectWidth-1:0] r_fifo [MaxWTrans];
  logic [PtrW-1:0]        r_wptr, r_rptr;
  logic [CntW-1:0]        r_cnt;

  always_comb begin
    for (int i = 0; i < NoSlvPorts; i++) begin
      w_aw_req[i] = slv_reqs_i[i].aw_valid;
      w_ar_req[i] = slv_reqs_i[i].ar_valid;
    end
  end

  axi_mux_rr_arb #(.N(NoSlvPorts)) u_aw_arb (
    .i_clk(clk_i), .i_rst(rst_i), .i_req(w_aw_req), .i_lock(r_aw_lock),
    .i_hs(w_aw_hs), .o_gnt_idx(w_aw_idx), .o_gnt_valid(w_aw_gnt));

  axi_mux_rr_arb #(.N(NoSlvPorts)) u_ar_arb (
    .i_clk(clk_i), .i_rst(rst_i), .i_req(w_ar_req), .i_lock(r_ar_lock),
    .i_hs(w_ar_hs), .o_gnt_idx(w_ar_idx), .o_gnt_valid(w_ar_gnt));

  assign w_full  = (r_cnt == CntW'(MaxWTrans));
  assign w_empty = (r_cnt == '0);
  assign w_w_idx = r_fifo[r_rptr];
  assign w_b_idx = mst_resp_i.b.id[SlvIdWidth +: SelectWidth];
  assign w_r_idx = mst_resp_i.r.id[SlvIdWidth +: SelectWidth];
  assign w_aw_hs = !rst_i && w_aw_gnt && !w_full && mst_resp_i.aw_ready;
  assign w_ar_hs = !rst_i && w_ar_gnt && mst_resp_i.ar_ready;
  assign w_pop   = !rst_i && !w_empty && slv_reqs_i[w_w_idx].w_valid &&
                   mst_resp_i.w_ready && slv_reqs_i[w_w_idx].w.last;

  always_comb begin
    mst_req_o   = '0;
    slv_resps_o = '0;
    if (!rst_i) begin
      mst_req_o.aw       = slv_reqs_i[w_aw_idx].aw;
      mst_req_o.aw.id    = prefix_id(w_aw_idx, slv_reqs_i[w_aw_idx].aw.id);
      mst_req_o.aw_valid = w_aw_gnt && !w_full;
      slv_resps_o[w_aw_idx].aw_ready = w_aw_gnt && !w_full && mst_resp_i.aw_ready;

      mst_req_o.ar       = slv_reqs_i[w_ar_idx].ar;
      mst_req_o.ar.id    = prefix_id(w_ar_idx, slv_reqs_i[w_ar_idx].ar.id);
      mst_req_o.ar_valid = w_ar_gnt;
      slv_resps_o[w_ar_idx].ar_ready = w_ar_gnt && mst_resp_i.ar_ready;

      if (!w_empty) begin
        mst_req_o.w       = slv_reqs_i[w_w_idx].w;
        mst_req_o.w_valid = slv_reqs_i[w_w_idx].w_valid;
        slv_resps_o[w_w_idx].w_ready = mst_resp_i.w_ready;
      end

      // Unmapped prefixes are sunk so the slave device cannot hang.
      if (int'(w_b_idx) < NoSlvPorts) begin
        slv_resps_o[w_b_idx].b_valid = mst_resp_i.b_valid;
        slv_resps_o[w_b_idx].b.id    = strip_id(mst_resp_i.b.id);
        slv_resps_o[w_b_idx].b.resp  = mst_resp_i.b.resp;
        mst_req_o.b_ready            = slv_reqs_i[w_b_idx].b_ready;
      end else begin
        mst_req_o.b_ready = 1'b1;
      end

      if (int'(w_r_idx) < NoSlvPorts) begin
        slv_resps_o[w_r_idx].r_valid = mst_resp_i.r_valid;
        slv_resps_o[w_r_idx].r       = '{id: strip_id(mst_resp_i.r.id), data: mst_resp_i.r.data,
                                         resp: mst_resp_i.r.resp, last: mst_resp_i.r.last};
        mst_req_o.r_ready            = slv_reqs_i[w_r_idx].r_ready;
      end else begin
        mst_req_o.r_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_lock <= 1'b0;
      r_ar_lock <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
    end else begin
      r_aw_lock <= w_aw_gnt && !w_full && !mst_resp_i.aw_ready;
      r_ar_lock <= w_ar_gnt && !mst_resp_i.ar_ready;
      if (w_aw_hs) begin
        r_fifo[r_wptr] <= w_aw_idx;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CntW'(w_aw_hs) - CntW'(w_pop);
    end
  end

  a_b_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.b_valid |-> int'(w_b_idx) < NoSlvPorts);
  a_r_idx: assert property (@(posedge clk_i) disable iff (rst_i)
    mst_resp_i.r_valid |-> int'(w_r_idx) < NoSlvPorts);
endmodule

// File: tb/tb_axi_mux_core.sv
// Directed bench for axi_mux_core: expected AW IDs, W beats and B/R returns are queued
// at stimulus time and a negedge monitor pops them on each observed handshake.
module tb_axi_mux_core;
  import axi_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  slv_req_t  [3:0] reqs;
  slv_resp_t [3:0] resps;
  mst_req_t        mreq;
  mst_resp_t       mresp;

  int total = 0;
  int bad   = 0;
  int exp_aw[$];
  int exp_w[$];
  int exp_b[$];
  int exp_r[$];

  always #5 clk = ~clk;

  axi_mux_core #(.SlvIdWidth(4), .NoSlvPorts(4), .MaxWTrans(8)) dut (
    .clk_i(clk), .rst_i(rst), .slv_reqs_i(reqs), .slv_resps_o(resps),
    .mst_req_o(mreq), .mst_resp_i(mresp));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst  = 1'b1;
    reqs = '0;
    tick();
    rst  = 1'b0;
  endtask

  // Monitor: compares every handshake against the head of the matching queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (mreq.aw_valid && mresp.aw_ready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", int'(mreq.aw.id), -1);
        else chk("aw_id", int'(mreq.aw.id), exp_aw.pop_front());
      end
      if (mreq.w_valid && mresp.w_ready) begin
        if (exp_w.size() == 0) chk("w_unexpected", int'(mreq.w.data), -1);
        else chk("w_beat", int'({mreq.w.last, mreq.w.data[23:0]}), exp_w.pop_front());
      end
      for (int p = 0; p < 4; p++) begin
        if (resps[p].b_valid && reqs[p].b_ready) begin
          if (exp_b.size() == 0) chk("b_unexpected", p, -1);
          else chk("b_route", (p << 8) | int'(resps[p].b.id), exp_b.pop_front());
        end
        if (resps[p].r_valid && reqs[p].r_ready) begin
          if (exp_r.size() == 0) chk("r_unexpected", p, -1);
          else chk("r_route", (p << 16) | (int'(resps[p].r.last) << 12) |
                   (int'(resps[p].r.id) << 8) | int'(resps[p].r.data[7:0]), exp_r.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    reqs  = '0;
    mresp = '0;
    rst   = 1'b1;

    // Reset state: a pending AW must not reach the master while in reset.
    reqs[0].aw_valid = 1'b1;
    reqs[0].aw.id    = 4'h5;
    mresp.aw_ready   = 1'b1;
    mresp.w_ready    = 1'b1;
    @(negedge clk);
    chk("rst_aw_valid", int'(mreq.aw_valid), 0);
    chk("rst_aw_ready", int'(resps[0].aw_ready), 0);
    chk("rst_w_valid", int'(mreq.w_valid), 0);
    tick();
    reqs = '0;
    tick();
    rst = 1'b0;

    // AW contention: 4 ports at once, RR grants 0..3.
    for (int p = 0; p < 4; p++) begin
      reqs[p].aw_valid = 1'b1;
      reqs[p].aw.id    = 4'h5;
      exp_aw.push_back(p * 16 + 5);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = -1;
      for (int p = 0; p < 4; p++) if (resps[p].aw_ready) g = p;
      chk("aw_rr_gnt", g, k);
      tick();
      if (g >= 0) reqs[g].aw_valid = 1'b0;
    end

    // AW lock: port 2 stalled for 3 cycles while port 1 joins.
    do_reset();
    mresp.aw_ready   = 1'b0;
    reqs[2].aw_valid = 1'b1;
    reqs[2].aw.id    = 4'h9;
    exp_aw.push_back('h29);
    exp_aw.push_back('h13);
    @(negedge clk);
    chk("aw_lock_first", int'(mreq.aw.id), 'h29);
    tick();
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'h3;
    repeat (2) begin
      @(negedge clk);
      chk("aw_lock_hold", int'(mreq.aw.id), 'h29);
    end
    tick();
    mresp.aw_ready = 1'b1;
    @(negedge clk);
    chk("aw_lock_hs", int'(resps[2].aw_ready), 1);
    tick();
    reqs[2].aw_valid = 1'b0;
    @(negedge clk);
    chk("aw_after_lock", int'(resps[1].aw_ready), 1);
    tick();
    reqs[1].aw_valid = 1'b0;

    // W ordering: port 1 (4 beats) before port 0 even though port 0 asserts W first.
    do_reset();
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'h1;
    reqs[1].aw.len   = 8'd3;
    reqs[0].w_valid  = 1'b1;
    reqs[0].w.data   = 32'hA0;
    reqs[0].w.last   = 1'b1;
    exp_aw.push_back('h11);
    exp_aw.push_back('h02);
    for (int b = 0; b < 4; b++) exp_w.push_back(((b == 3) ? (1 << 24) : 0) | ('hB0 + b));
    exp_w.push_back((1 << 24) | 'hA0);
    @(negedge clk);
    chk("w_empty_valid", int'(mreq.w_valid), 0);
    chk("w_empty_p0_ready", int'(resps[0].w_ready), 0);
    tick();
    reqs[1].aw_valid = 1'b0;
    reqs[0].aw_valid = 1'b1;
    reqs[0].aw.id    = 4'h2;
    reqs[0].aw.len   = 8'd0;
    reqs[1].w_valid  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      reqs[1].w.data = 32'hB0 + b;
      reqs[1].w.last = (b == 3);
      if (b == 1) reqs[0].aw_valid = 1'b0;
      @(negedge clk);
      chk("w_hold_p0", int'(resps[0].w_ready), 0);
      tick();
    end
    reqs[1].w_valid = 1'b0;
    @(negedge clk);
    chk("w_p0_ready", int'(resps[0].w_ready), 1);
    tick();
    reqs[0].w_valid = 1'b0;

    // W FIFO full: 8 AWs fill it, 9th blocked even with a same-cycle pop.
    do_reset();
    reqs[0].aw_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      reqs[0].aw.id = 4'(k);
      exp_aw.push_back(k);
      @(negedge clk);
      chk("fill_aw_ready", int'(resps[0].aw_ready), 1);
      tick();
    end
    reqs[0].aw.id   = 4'h8;
    reqs[0].w_valid = 1'b1;
    reqs[0].w.data  = 32'hC0;
    reqs[0].w.last  = 1'b1;
    exp_w.push_back((1 << 24) | 'hC0);
    @(negedge clk);
    chk("full_aw_ready", int'(resps[0].aw_ready), 0);
    chk("full_aw_valid", int'(mreq.aw_valid), 0);
    tick();
    reqs[0].w_valid = 1'b0;
    exp_aw.push_back(8);
    @(negedge clk);
    chk("after_pop_aw_ready", int'(resps[0].aw_ready), 1);
    tick();
    reqs[0].aw_valid = 1'b0;

    // B/R return by ID prefix.
    do_reset();
    reqs[2].b_ready = 1'b1;
    mresp.b_valid   = 1'b1;
    mresp.b.id      = 6'h27;
    exp_b.push_back((2 << 8) | 7);
    @(negedge clk);
    chk("b_valid_p2", int'(resps[2].b_valid), 1);
    chk("b_id_p2", int'(resps[2].b.id), 7);
    chk("b_valid_other", int'(resps[0].b_valid | resps[1].b_valid | resps[3].b_valid), 0);
    chk("b_ready_fwd", int'(mreq.b_ready), 1);
    tick();
    reqs[2].b_ready = 1'b0;
    @(negedge clk);
    chk("b_ready_bp", int'(mreq.b_ready), 0);
    tick();
    mresp.b_valid   = 1'b0;
    mresp.r_valid   = 1'b1;
    mresp.r.id      = 6'h3A;
    mresp.r.last    = 1'b1;
    mresp.r.data    = 32'hD0;
    reqs[3].r_ready = 1'b1;
    exp_r.push_back((3 << 16) | (1 << 12) | ('hA << 8) | 'hD0);
    @(negedge clk);
    chk("r_valid_p3", int'(resps[3].r_valid), 1);
    chk("r_id_p3", int'(resps[3].r.id), 'hA);
    chk("r_last_p3", int'(resps[3].r.last), 1);
    chk("r_valid_other", int'(resps[0].r_valid | resps[1].r_valid | resps[2].r_valid), 0);
    chk("r_ready_fwd", int'(mreq.r_ready), 1);
    tick();
    mresp.r_valid   = 1'b0;
    reqs[3].r_ready = 1'b0;

    // AR: independent RR from pointer 0, ports 1 and 3 requesting.
    mresp.ar_ready   = 1'b1;
    reqs[1].ar_valid = 1'b1;
    reqs[1].ar.id    = 4'h2;
    reqs[3].ar_valid = 1'b1;
    reqs[3].ar.id    = 4'h4;
    @(negedge clk);
    chk("ar_id_first", int'(mreq.ar.id), 'h12);
    chk("ar_ready_p1", int'(resps[1].ar_ready), 1);
    tick();
    reqs[1].ar_valid = 1'b0;
    @(negedge clk);
    chk("ar_id_second", int'(mreq.ar.id), 'h34);
    tick();
    reqs[3].ar_valid = 1'b0;

    // Reset mid-burst: W burst abandoned, RR pointer back to port 0.
    reqs[1].aw_valid = 1'b1;
    reqs[1].aw.id    = 4'h4;
    reqs[1].aw.len   = 8'd3;
    exp_aw.push_back('h14);
    tick();
    reqs[1].aw_valid = 1'b0;
    reqs[1].w_valid  = 1'b1;
    reqs[1].w.data   = 32'hE0;
    reqs[1].w.last   = 1'b0;
    exp_w.push_back('hE0);
    tick();
    rst              = 1'b1;
    reqs[1].w.data   = 32'hE1;
    reqs[2].aw_valid = 1'b1;
    reqs[2].aw.id    = 4'h1;
    @(negedge clk);
    chk("rst_mid_w_valid", int'(mreq.w_valid), 0);
    chk("rst_mid_w_ready", int'(resps[1].w_ready), 0);
    chk("rst_mid_aw_valid", int'(mreq.aw_valid), 0);
    chk("rst_mid_aw_ready", int'(resps[2].aw_ready), 0);
    tick();
    rst = 1'b0;
    for (int p = 0; p < 4; p++) begin
      reqs[p].aw_valid = 1'b1;
      reqs[p].aw.id    = 4'h5;
    end
    exp_aw.push_back('h05);
    @(negedge clk);
    chk("post_rst_w_valid", int'(mreq.w_valid), 0);
    chk("post_rst_w_ready", int'(resps[1].w_ready), 0);
    chk("post_rst_gnt_p0", int'(resps[0].aw_ready), 1);
    tick();
    reqs = '0;
    repeat (2) tick();

    chk("sb_drained", exp_aw.size() + exp_w.size() + exp_b.size() + exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
